// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus: UART byte stream in, instruction-memory write port and load status out.
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              recv_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (input rx_valid, rx_data,
                  output imem_we, imem_addr, imem_wdata, recv_done, load_err, words_loaded);
  modport slave  (output rx_valid, rx_data,
                  input imem_we, imem_addr, imem_wdata, recv_done, load_err, words_loaded);
endinterface

// File: rtl/imem_boot_loader.sv
// Assembles a framed serial byte image into 32-bit words, writes them to instruction
// memory and raises recv_done once the XOR checksum matches.
module imem_boot_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1_000_000,
  parameter int CNT_W   = 20
) (
  input  logic clk,
  input  logic reset,
  imem_boot_loader_if.master bus
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE} state_t;

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t            state;
  logic [7:0]        n_hi;
  logic [ADDR_W:0]   num;
  logic [ADDR_W:0]   k;
  logic [1:0]        byte_idx;
  logic [23:0]       word;
  logic [7:0]        acc;
  logic [CNT_W-1:0]  idle_cnt;
  logic              imem_we, recv_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [15:0]       hdr_n;
  logic              timing;

  assign hdr_n  = {n_hi, bus.rx_data};
  assign timing = (state == HDR1) || (state == DATA) || (state == CHK);

  // k doubles as the words_loaded counter; both clear and step together.
  assign bus.imem_we      = imem_we;
  assign bus.imem_addr    = imem_addr;
  assign bus.imem_wdata   = imem_wdata;
  assign bus.recv_done    = recv_done;
  assign bus.load_err     = load_err;
  assign bus.words_loaded = k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HDR0;
      n_hi       <= '0;
      num        <= '0;
      k          <= '0;
      byte_idx   <= '0;
      word       <= '0;
      acc        <= '0;
      idle_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      recv_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      load_err <= 1'b0;

      // rx_valid and timeout firing are exclusive, so the byte case below never collides.
      if (timing && !bus.rx_valid) begin
        if (idle_cnt == CNT_W'(TIMEOUT - 1)) begin
          load_err <= 1'b1;
          state    <= HDR0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      if (bus.rx_valid) begin
        case (state)
          HDR0: begin
            n_hi  <= bus.rx_data;
            state <= HDR1;
          end
          HDR1: begin
            if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_N) begin
              load_err <= 1'b1;
              state    <= HDR0;
            end else begin
              num      <= hdr_n[ADDR_W:0];
              k        <= '0;
              byte_idx <= '0;
              acc      <= '0;
              state    <= DATA;
            end
          end
          DATA: begin
            word     <= {word[15:0], bus.rx_data};
            acc      <= acc ^ bus.rx_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= k[ADDR_W-1:0];
              imem_wdata <= {word, bus.rx_data};
              k          <= k + 1'b1;
              if (k + 1'b1 == num) state <= CHK;
            end
          end
          CHK: begin
            if (bus.rx_data == acc) begin
              recv_done <= 1'b1;
              state     <= DONE;
            end else begin
              load_err <= 1'b1;
              state    <= HDR0;
            end
          end
          DONE:    state <= DONE;
          default: state <= HDR0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboarded bench: expected writes queued as frames are driven, checked as imem_we fires.
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 0, reset = 1;
  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int err_cnt = 0, exp_errs = 0;
  wr_t exp_q[$];
  logic [31:0] img[256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.imem_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.imem_addr, e.addr);
          chk("wr_data", bus.imem_wdata, e.data);
        end
      end
      if (bus.load_err) err_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1;
    bus.rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  // stop_at: abandon after that many data bytes; gap_at/gap_len: insert idle cycles.
  task automatic send_frame(input int n, input bit bad, input int stop_at,
                            input int gap_at, input int gap_len);
    logic [7:0] x, b;
    int cnt;
    wr_t e;
    x = 0; cnt = 0;
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    if (n == 0 || n > 256) begin
      exp_errs++;
      bus.rx_valid = 0;
      return;
    end
    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[w][31-8*j -: 8];
        x ^= b;
        if (j == 3) begin
          e.addr = w[ADDR_W-1:0];
          e.data = img[w];
          exp_q.push_back(e);
        end
        send_byte(b);
        cnt++;
        if (cnt == stop_at) begin
          bus.rx_valid = 0;
          return;
        end
        if (cnt == gap_at) idle(gap_len);
      end
    end
    send_byte(x ^ {7'd0, bad});
    bus.rx_valid = 0;
    if (bad) exp_errs++;
  endtask

  task automatic do_reset();
    reset = 1;
    bus.rx_valid = 0;
    bus.rx_data = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic settle(input string tag);
    idle(3);
    chk({tag, "_errs"}, err_cnt, exp_errs);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int i;
    bus.rx_valid = 0;
    bus.rx_data  = 0;
    img[0] = 32'h3C011234;
    img[1] = 32'h00000000;
    repeat (2) @(negedge clk);
    chk("rst_we", bus.imem_we, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_wdata", bus.imem_wdata, 0);
    chk("rst_done", bus.recv_done, 0);
    chk("rst_err", bus.load_err, 0);
    chk("rst_words", bus.words_loaded, 0);
    reset = 0;
    @(negedge clk);

    // bad headers
    send_frame(0, 0, 0, 0, 0);
    settle("hdr0000");
    send_frame(257, 0, 0, 0, 0);
    settle("hdr0101");

    // bad checksum (0x1A) then good frame (0x1B)
    send_frame(2, 1, 0, 0, 0);
    chk("bad_done", bus.recv_done, 0);
    settle("badchk");
    send_frame(2, 0, 0, 0, 0);
    chk("good_done", bus.recv_done, 1);
    chk("good_words", bus.words_loaded, 2);
    settle("good");

    // bytes after done are ignored
    for (int r = 0; r < 10; r++) send_byte(8'($urandom_range(0, 255)));
    chk("post_done", bus.recv_done, 1);
    chk("post_words", bus.words_loaded, 2);
    settle("post");

    // timeout after 3 data bytes
    do_reset();
    send_frame(2, 0, 3, 0, 0);
    i = 1;
    while (i <= 40) begin
      @(negedge clk);
      if (bus.load_err) break;
      i++;
    end
    chk("to_latency", i, TIMEOUT);
    exp_errs++;
    exp_q.delete();
    settle("timeout");

    // 15 idle cycles then a byte: boundary, no error
    send_frame(2, 0, 0, 3, 15);
    chk("gap15_done", bus.recv_done, 1);
    settle("gap15");

    // reset mid-load after 5 data bytes
    do_reset();
    send_frame(2, 0, 5, 0, 0);
    chk("mid_words", bus.words_loaded, 1);
    #2 reset = 1;
    #1;
    chk("mr_we", bus.imem_we, 0);
    chk("mr_addr", bus.imem_addr, 0);
    chk("mr_wdata", bus.imem_wdata, 0);
    chk("mr_done", bus.recv_done, 0);
    chk("mr_err", bus.load_err, 0);
    chk("mr_words", bus.words_loaded, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    send_frame(2, 0, 0, 0, 0);
    chk("reload_done", bus.recv_done, 1);
    settle("reload");

    // full-size back-to-back image
    do_reset();
    for (int w = 0; w < 256; w++) img[w] = $urandom;
    send_frame(256, 0, 0, 0, 0);
    chk("big_done", bus.recv_done, 1);
    chk("big_words", bus.words_loaded, 256);
    chk("big_last_addr", bus.imem_addr, 255);
    settle("big");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time sequencer for the fetch stage. It receives a program image as a serial byte stream from the UART receiver, assembles the bytes into 32-bit instruction words, and writes them into instruction memory. When the image is verified, it raises `recv_done`. The PC / IF-ID stage holds its reset state (PC = 0x00000004, jump-to-boot instruction in ID) until `recv_done` rises.

## Interface
Parameters:
- `ADDR_W`, default 8: instruction-memory word-address width; maximum image size is 2^ADDR_W words.
- `TIMEOUT`, default 1_000_000: maximum idle clk cycles allowed between bytes once a load has started.
- `CNT_W`, default 20: width of the timeout counter; must satisfy 2^CNT_W ≥ TIMEOUT.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_valid`  in  1  single-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte.
- `imem_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word to write.
- `recv_done`  out  1  image loaded and checksum verified; sticky until reset.
- `load_err`  out  1  one-cycle pulse on any aborted load.
- `words_loaded`  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- Frame format, in byte order:
  - 2-byte word count N, big-endian, with 1 ≤ N ≤ 2^ADDR_W.
  - 4·N data bytes; each word is big-endian (first byte goes to bits [31:24]).
  - 1 checksum byte equal to the XOR of all 4·N data bytes.
- The loader always accepts bytes. There is no backpressure and no ready signal.
- FSM states and transitions:
  - HDR0: capture N[15:8]; go to HDR1.
  - HDR1: capture N[7:0]. If N = 0 or N > 2^ADDR_W, pulse `load_err` and go to HDR0. Otherwise clear the word index, byte index, XOR accumulator and `words_loaded`, then go to DATA.
  - DATA: shift the byte into the word register and XOR it into the accumulator. On the 4th byte of a word, write word k to address k and increment k and `words_loaded`. After word N−1 is written, go to CHK.
  - CHK: if the byte equals the accumulator, set `recv_done` and go to DONE. Otherwise pulse `load_err` and go to HDR0.
  - DONE: ignore all `rx_valid`; `recv_done` stays 1; no further writes.
- Timeout:
  - In HDR1, DATA and CHK, the idle counter increments on each cycle without `rx_valid` and clears on `rx_valid`.
  - When the counter reaches TIMEOUT−1 with no `rx_valid` in that cycle, pulse `load_err` and go to HDR0.
  - HDR0 and DONE do not time out.
- Words already written by an aborted load stay in memory. Recovery is a full reload from HDR0.
- Address arithmetic: k is ADDR_W+1 bits wide. When N = 2^ADDR_W, `imem_addr` = k[ADDR_W-1:0] and k never wraps before CHK.

## Timing
- Reset values: FSM = HDR0; `imem_we` = 0; `imem_addr` = 0; `imem_wdata` = 0; `recv_done` = 0; `load_err` = 0; `words_loaded` = 0; all counters = 0.
- Reset asserted mid-load aborts immediately. No `load_err` pulse is generated.
- All outputs are registered.
- Write latency: when the edge samples the 4th byte of a word, `imem_we`/`imem_addr`/`imem_wdata` are valid for the following cycle only.
- `recv_done` rises on the edge that samples a matching checksum byte.
- `load_err` is high for exactly one cycle after the offending edge: bad header, checksum mismatch, or timeout.
- Back-to-back `rx_valid` on every cycle is supported. Consecutive write pulses can therefore be 4 cycles apart at minimum.
- Simultaneous events:
  - `rx_valid` in the cycle the timeout would fire: the byte is taken and the counter clears.
  - The last data byte and the write pulse for the final word: the FSM is in CHK in the same cycle the write completes, so a checksum byte arriving in that cycle is accepted.

## Test plan
- Load N=2, words 0x3C011234 and 0x00000000, checksum 0x3C^0x01^0x12^0x34 = 0x1B → two write pulses (addr 0 then addr 1) with the correct data; `recv_done`=1 one edge after the checksum byte; `words_loaded`=2.
- Same frame with checksum 0x1A → both writes occur, `load_err` pulses once, `recv_done` stays 0. A following correct frame → `recv_done`=1.
- Header 0x0000, and header 0x0101 with ADDR_W=8 → `load_err` after the 2nd byte, no writes, FSM back in HDR0.
- TIMEOUT=16: stop sending after 3 data bytes → `load_err` exactly 16 idle cycles later, no write. Byte arriving at idle cycle 15 → no error.
- Assert reset after 5 data bytes → all outputs return to reset values immediately. A full reload then succeeds.
- After `recv_done`, send 10 random bytes → no `imem_we`, no `load_err`, `recv_done` remains 1. Also run an N=256 load with `rx_valid` on every cycle → last write to addr 255, `words_loaded`=256.
